// File: rtl/pic_inta_sequencer.sv
// 8259 interrupt-service sequencer: owns ISR and the rotating priority pointer,
// arbitrates pending requests, drives INT and runs the two-pulse INTA handshake.
module pic_inta_sequencer #(
  parameter int INTA_TIMEOUT   = 255,
  parameter int SPURIOUS_LEVEL = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_done,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       auto_rotate,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  input  logic       inta_n,
  output logic       int_o,
  output logic [7:0] isr,
  output logic [7:0] irr_clear,
  output logic       vec_oe,
  output logic [7:0] vec,
  output logic [2:0] lowest_prio,
  output logic [1:0] ack_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } state_t;

  state_t     state;
  logic       inta_prev;
  logic [7:0] tmo_cnt;
  logic [2:0] level;
  logic       spurious;

  logic [7:0] pending;
  logic       pend_any;
  logic [2:0] win;
  logic [2:0] svc;
  logic       int_cond;
  logic       fall;
  logic       rise;
  logic       eoi_hit;
  logic [2:0] eoi_lvl;
  logic [7:0] eoi_mask;
  logic       ack_set;
  logic [7:0] set_mask;
  logic       aeoi_done;
  logic [7:0] aeoi_mask;
  logic [7:0] isr_next;
  logic [2:0] lp_next;

  // Highest-priority set bit of v: scan upward from the level just above lp.
  function automatic logic [2:0] top_level(input logic [7:0] v, input logic [2:0] lp);
    logic [2:0] lvl;
    logic       found;
    top_level = 3'd0;
    found     = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      lvl = lp + 3'(k);
      if (v[lvl] && !found) begin
        top_level = lvl;
        found     = 1'b1;
      end
    end
  endfunction

  // Rank 0 is the highest priority under the current rotation.
  function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lp);
    rank = lvl - lp - 3'd1;
  endfunction

  // NOTE: combinational logic uses blocking '=' with a default for every output
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pending   = irr & ~imr;
    pend_any  = |pending;
    win       = top_level(pending, lowest_prio);
    svc       = top_level(isr, lowest_prio);
    int_cond  = pend_any && ((isr == 8'd0) || (rank(win, lowest_prio) < rank(svc, lowest_prio)));

    fall      = inta_prev & ~inta_n;
    rise      = ~inta_prev & inta_n;

    eoi_hit   = eoi_valid && (eoi_specific || (isr != 8'd0));
    eoi_lvl   = eoi_specific ? eoi_level : svc;
    eoi_mask  = eoi_hit ? (8'b1 << eoi_lvl) : 8'd0;

    ack_set   = (state == IDLE) && fall && pend_any;
    set_mask  = ack_set ? (8'b1 << win) : 8'd0;

    aeoi_done = (state == ACK2) && rise && aeoi && !spurious;
    aeoi_mask = aeoi_done ? (8'b1 << level) : 8'd0;

    // Clears use the pre-set ISR; the set is applied last so it wins on overlap.
    isr_next  = (isr & ~eoi_mask & ~aeoi_mask) | set_mask;

    lp_next   = lowest_prio;
    if (eoi_hit && eoi_rotate) begin
      lp_next = eoi_lvl;
    end else if (aeoi_done && auto_rotate) begin
      lp_next = level;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' only; reset is synchronous and
  // also taken while configuration is incomplete.
  always_ff @(posedge clk) begin
    if (!rst_n || !cfg_done) begin
      state       <= IDLE;
      inta_prev   <= 1'b1;
      tmo_cnt     <= 8'd0;
      level       <= 3'd0;
      spurious    <= 1'b0;
      int_o       <= 1'b0;
      isr         <= 8'd0;
      irr_clear   <= 8'd0;
      vec_oe      <= 1'b0;
      vec         <= 8'd0;
      lowest_prio <= 3'd7;
    end else begin
      inta_prev   <= inta_n;
      isr         <= isr_next;
      lowest_prio <= lp_next;
      irr_clear   <= set_mask;
      int_o       <= (state == IDLE) && !fall && int_cond;

      case (state)
        IDLE: begin
          tmo_cnt <= 8'd0;
          if (fall) begin
            state    <= ACK1;
            level    <= pend_any ? win : 3'(SPURIOUS_LEVEL);
            spurious <= !pend_any;
          end
        end
        default: begin
          if (state == ACK1 && rise) begin
            state   <= GAP;
            tmo_cnt <= 8'd0;
          end else if (state == GAP && fall) begin
            state   <= ACK2;
            tmo_cnt <= 8'd0;
            vec_oe  <= 1'b1;
            vec     <= {vector_base, level};
          end else if (state == ACK2 && rise) begin
            state   <= IDLE;
            tmo_cnt <= 8'd0;
            vec_oe  <= 1'b0;
          end else if (tmo_cnt == 8'(INTA_TIMEOUT - 1)) begin
            // Abandoned handshake: ISR keeps whatever the first INTA set.
            state   <= IDLE;
            tmo_cnt <= 8'd0;
            vec_oe  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign ack_state = state;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: vector table, directed corner
// sequences and randomized traffic against a transaction-level priority model.
module tb_pic_inta_sequencer;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_done;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       auto_rotate;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       eoi_rotate;
  logic       inta_n;
  logic       int_o;
  logic [7:0] isr;
  logic [7:0] irr_clear;
  logic       vec_oe;
  logic [7:0] vec;
  logic [2:0] lowest_prio;
  logic [1:0] ack_state;

  pic_inta_sequencer #(.INTA_TIMEOUT(TMO), .SPURIOUS_LEVEL(7)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_done(cfg_done), .irr(irr), .imr(imr),
    .vector_base(vector_base), .aeoi(aeoi), .auto_rotate(auto_rotate),
    .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .eoi_rotate(eoi_rotate), .inta_n(inta_n), .int_o(int_o), .isr(isr),
    .irr_clear(irr_clear), .vec_oe(vec_oe), .vec(vec), .lowest_prio(lowest_prio),
    .ack_state(ack_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ISR contents and lowest-priority level.
  logic [7:0] m_isr;
  int         m_lp;

  typedef struct {
    logic [7:0] irr;
    logic [7:0] imr;
    logic       exp_int;
    logic [7:0] exp_clr;
    logic [7:0] exp_vec;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Distance below the top priority: level lp+1 is 0, lp itself is 7.
  function automatic int rank_of(input int lvl, input int lp);
    return (lvl - lp + 7) % 8;
  endfunction

  function automatic int best(input logic [7:0] v, input int lp);
    int b = -1;
    for (int i = 0; i < 8; i++)
      if (v[i] && (b < 0 || rank_of(i, lp) < rank_of(b, lp))) b = i;
    return b;
  endfunction

  function automatic logic exp_int(input logic [7:0] r, input logic [7:0] m,
                                   input logic [7:0] s, input int lp);
    logic [7:0] p = r & ~m;
    if (p == 8'd0) return 1'b0;
    if (s == 8'd0) return 1'b1;
    return rank_of(best(p, lp), lp) < rank_of(best(s, lp), lp);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_isr = 8'd0;
    m_lp  = 7;
  endtask

  // Raw two-pulse handshake returning what the DUT showed.
  task automatic pulse_pair(output logic [7:0] clr, output logic [7:0] v, output logic oe);
    inta_n = 1'b0; tick(); clr = irr_clear;
    tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick(); oe = vec_oe; v = vec;
    inta_n = 1'b1; tick();
  endtask

  // Model-checked handshake; the bench acts as the IRR latch and clears the bit.
  task automatic handshake();
    logic [7:0] p;
    logic [7:0] clr;
    int         lvl;
    p = irr & ~imr;
    if (p != 8'd0) begin
      lvl = best(p, m_lp);
      clr = 8'(1 << lvl);
    end else begin
      lvl = 7;
      clr = 8'd0;
    end
    m_isr |= clr;
    inta_n = 1'b0; tick();
    check("ack1_isr", isr, m_isr);
    check("ack1_irr_clear", irr_clear, clr);
    check("ack1_state", ack_state, 1);
    irr = irr & ~clr;
    tick();
    check("irr_clear_one_cycle", irr_clear, 0);
    inta_n = 1'b1; tick();
    check("gap_state", ack_state, 2);
    inta_n = 1'b0; tick();
    check("ack2_vec_oe", vec_oe, 1);
    check("ack2_vec", vec, {vector_base, 3'(lvl)});
    inta_n = 1'b1; tick();
    if (aeoi && p != 8'd0) begin
      m_isr &= ~clr;
      if (auto_rotate) m_lp = lvl;
    end
    check("end_vec_oe", vec_oe, 0);
    check("end_isr", isr, m_isr);
    check("end_lowest_prio", lowest_prio, m_lp);
    check("end_state", ack_state, 0);
  endtask

  task automatic do_eoi(input logic spec, input int lvl, input logic rot);
    int c = -1;
    if (spec) c = lvl;
    else if (m_isr != 8'd0) c = best(m_isr, m_lp);
    if (c >= 0) begin
      m_isr &= ~8'(1 << c);
      if (rot) m_lp = c;
    end
    eoi_specific = spec;
    eoi_level    = 3'(lvl);
    eoi_rotate   = rot;
    eoi_valid    = 1'b1;
    tick();
    eoi_valid    = 1'b0;
    check("eoi_isr", isr, m_isr);
    check("eoi_lowest_prio", lowest_prio, m_lp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] clr_s;
    logic [7:0] vec_s;
    logic       oe_s;
    int         n;

    tbl[0] = '{8'h24, 8'h00, 1'b1, 8'h04, 8'h42};
    tbl[1] = '{8'h24, 8'h04, 1'b1, 8'h20, 8'h45};
    tbl[2] = '{8'h80, 8'h00, 1'b1, 8'h80, 8'h47};
    tbl[3] = '{8'hFF, 8'hFE, 1'b1, 8'h01, 8'h40};
    tbl[4] = '{8'h0F, 8'h0F, 1'b0, 8'h00, 8'h47};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h47};
    tbl[6] = '{8'h18, 8'h08, 1'b1, 8'h10, 8'h44};

    rst_n = 1'b0; cfg_done = 1'b1; irr = 8'd0; imr = 8'd0;
    vector_base = 5'b01000; aeoi = 1'b0; auto_rotate = 1'b0;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; eoi_rotate = 1'b0;
    inta_n = 1'b1;
    repeat (2) tick();
    do_reset();

    check("rst_int_o", int_o, 0);
    check("rst_isr", isr, 0);
    check("rst_irr_clear", irr_clear, 0);
    check("rst_vec_oe", vec_oe, 0);
    check("rst_vec", vec, 0);
    check("rst_lowest_prio", lowest_prio, 7);
    check("rst_state", ack_state, 0);

    // Vector table: arbitration, ack bit and vector from the reset priority order.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      irr = tbl[i].irr;
      imr = tbl[i].imr;
      tick();
      check($sformatf("tbl%0d_int_o", i), int_o, tbl[i].exp_int);
      pulse_pair(clr_s, vec_s, oe_s);
      check($sformatf("tbl%0d_irr_clear", i), clr_s, tbl[i].exp_clr);
      check($sformatf("tbl%0d_vec_oe", i), oe_s, 1);
      check($sformatf("tbl%0d_vec", i), vec_s, tbl[i].exp_vec);
      check($sformatf("tbl%0d_isr", i), isr, tbl[i].exp_clr);
    end

    // Nesting: IR2 in service blocks IR7 but IR0 preempts.
    do_reset(); irr = 8'h00; imr = 8'h00;
    irr = 8'h04; tick();
    handshake();
    tick(); check("nest_int_after_clear", int_o, 0);
    irr = 8'h80; tick(); check("nest_int_lower", int_o, 0);
    irr = 8'h01; tick(); check("nest_int_higher", int_o, 1);

    // AEOI with rotation: IR3 serviced, then IR4 becomes top priority.
    do_reset(); aeoi = 1'b1; auto_rotate = 1'b1;
    irr = 8'h08; tick();
    handshake();
    check("aeoi_isr_zero", isr, 0);
    check("aeoi_rotate_lp", lowest_prio, 3);
    irr = 8'h18; tick();
    check("aeoi_int", int_o, 1);
    handshake();
    check("aeoi_ir4_lp", lowest_prio, 4);
    aeoi = 1'b0; auto_rotate = 1'b0;

    // EOI flavours on isr=0A.
    do_reset();
    irr = 8'h08; tick(); handshake();
    irr = 8'h02; tick(); check("eoi_setup_int", int_o, 1);
    handshake();
    check("eoi_setup_isr", isr, 8'h0A);
    do_eoi(1'b0, 0, 1'b0);
    check("ns_eoi_isr", isr, 8'h08);
    do_eoi(1'b1, 3, 1'b1);
    check("sp_eoi_isr", isr, 8'h00);
    check("sp_eoi_lp", lowest_prio, 3);

    // Same-cycle first INTA and non-specific EOI: EOI picks from old ISR.
    do_reset();
    irr = 8'h08; tick(); handshake();
    irr = 8'h02;
    inta_n = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_valid = 1'b1;
    tick();
    eoi_valid = 1'b0;
    check("same_cycle_isr", isr, 8'h02);
    check("same_cycle_clr", irr_clear, 8'h02);
    irr = 8'h00;
    tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    check("same_cycle_vec", vec, 8'h41);
    inta_n = 1'b1; tick();
    m_isr = 8'h02;

    // Reset while in GAP with non-default ISR, pointer and vector.
    do_eoi(1'b1, 5, 1'b1);
    irr = 8'h01;
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    check("gap_before_reset", ack_state, 2);
    rst_n = 1'b0; tick();
    check("gaprst_int_o", int_o, 0);
    check("gaprst_isr", isr, 0);
    check("gaprst_irr_clear", irr_clear, 0);
    check("gaprst_vec_oe", vec_oe, 0);
    check("gaprst_vec", vec, 0);
    check("gaprst_lp", lowest_prio, 7);
    check("gaprst_state", ack_state, 0);
    rst_n = 1'b1; m_isr = 8'd0; m_lp = 7;

    // cfg_done low holds the block in reset.
    irr = 8'h04; tick(); handshake();
    cfg_done = 1'b0; tick();
    check("cfg_isr", isr, 0);
    check("cfg_int_o", int_o, 0);
    cfg_done = 1'b1; m_isr = 8'd0;

    // Timeout in GAP: ISR keeps the bit set by the first INTA.
    do_reset();
    irr = 8'h04; tick();
    inta_n = 1'b0; tick();
    irr = 8'h00;
    inta_n = 1'b1; tick();
    check("tmo_in_gap", ack_state, 2);
    n = 0;
    while (ack_state != 2'd0 && n < TMO + 5) begin
      tick();
      n++;
    end
    check("tmo_cycles_in_window", (n >= TMO && n <= TMO + 1), 1);
    check("tmo_state", ack_state, 0);
    check("tmo_isr", isr, 8'h04);
    check("tmo_vec_oe", vec_oe, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int it = 0; it < 200; it++) begin
      vector_base = 5'($urandom);
      irr = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      imr = 8'($urandom & $urandom & $urandom);
      tick();
      check("rnd_int_o", int_o, exp_int(irr, imr, m_isr, m_lp));
      if ($urandom_range(0, 1) == 1) begin
        aeoi        = 1'($urandom);
        auto_rotate = 1'($urandom);
        handshake();
      end
      if ($urandom_range(0, 2) == 0)
        do_eoi(1'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- Clocked interrupt-service sequencer for the 8259 PIC.
- Owns the In-Service Register (ISR) and the rotating priority pointer. Arbitrates the unmasked IRR bits, drives INT, and runs the two-pulse INTA handshake that sets ISR and places the vector on the bus.
- Applies EOI and rotation commands decoded from OCW2.
- Sits between the ICW/OCW register block, which supplies configuration and commands, and the data bus buffer, which receives the vector.

Parameters:
- INTA_TIMEOUT, 255: cycles allowed between consecutive INTA edges inside a handshake before abort; legal range 1..255, 8-bit counter.
- SPURIOUS_LEVEL, 7: level reported in the vector when no request is pending at the first INTA.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cfg_done  in  1  ICW sequence complete; 0 holds the block in its reset state
- irr  in  8  latched interrupt request register
- imr  in  8  interrupt mask (OCW1); 1 = masked
- vector_base  in  5  ICW2[7:3]
- aeoi  in  1  ICW4 auto-EOI enable
- auto_rotate  in  1  rotate-in-AEOI mode (from OCW2)
- eoi_valid  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific
- eoi_level  in  3  level for specific EOI
- eoi_rotate  in  1  rotate on this EOI (OCW2 R bit)
- inta_n  in  1  INTA, already synchronised to clk, active low
- int_o  out  1  interrupt request to CPU
- isr  out  8  in-service register
- irr_clear  out  8  one-hot, one-cycle pulse to clear the acknowledged IRR bit
- vec_oe  out  1  vector drive enable to data bus buffer
- vec  out  8  {vector_base, level}
- lowest_prio  out  3  current lowest-priority level
- ack_state  out  2  FSM state: 0 IDLE, 1 ACK1, 2 GAP, 3 ACK2

Behaviour:
- Reset (rst_n=0 at a clk edge, or cfg_done=0):
  - int_o=0, isr=0, irr_clear=0, vec_oe=0, vec=0, lowest_prio=7, state IDLE, timeout counter 0.
  - INTA edge history register set to 1.
- Priority order: (lowest_prio+1) mod 8 is highest, ascending with wrap-around, lowest_prio is lowest. After reset IR0 is highest and IR7 lowest.
- Arbitration:
  - pending = irr & ~imr.
  - win = highest-priority bit of pending.
  - svc = highest-priority bit of isr.
- int_o is registered. It is 1 in IDLE when pending≠0 and either (isr==0 or win outranks svc). It asserts 1 cycle after the condition holds and is 0 in all states other than IDLE.
- Edge detection: a falling edge is prev=1 & inta_n=0; a rising edge is prev=0 & inta_n=1. prev is registered every cycle.
- FSM:
  - IDLE → ACK1 on falling edge.
    - Level := win. Set isr[win] and pulse irr_clear[win] for 1 cycle.
    - If pending==0: spurious. Level := SPURIOUS_LEVEL, isr unchanged, irr_clear=0.
  - ACK1 → GAP on rising edge.
  - GAP → ACK2 on falling edge. Next cycle vec_oe=1, vec={vector_base, level}.
  - ACK2 → IDLE on rising edge. Next cycle vec_oe=0.
    - If aeoi and not spurious: clear isr[level].
    - If additionally auto_rotate: lowest_prio := level.
- Timeout: the counter resets on every state change and increments in ACK1, GAP and ACK2. Reaching INTA_TIMEOUT forces IDLE and vec_oe=0; isr is left as already set.
- EOI (eoi_valid=1, accepted in any state):
  - Specific: clear isr[eoi_level].
  - Non-specific: clear the highest-priority set isr bit; no-op if isr==0.
  - If eoi_rotate and a bit was cleared (specific always counts): lowest_prio := cleared level.
- Same-cycle ISR set (first INTA) and EOI clear:
  - Both apply.
  - If the bits coincide, the set wins.
  - A non-specific EOI selects among isr bits before the set.
- Same-cycle AEOI rotation and EOI rotation: the EOI rotation wins.
- irr and imr changes during a handshake do not alter the captured level.

Test Plan:
- Reset, cfg_done=1, vector_base=5'b01000, irr=8'h24, imr=0 → int_o=1; INTA pulse 1 → isr=8'h04, irr_clear=8'h04 for one cycle; INTA pulse 2 → vec_oe=1, vec=8'h42; int_o stays 0 while irr bit 2 is cleared.
- isr=8'h04, irr=8'h80 → int_o=0 (lower priority); irr=8'h01 → int_o=1 (nesting).
- aeoi=1, auto_rotate=1, service IR3 → after INTA pulse 2 isr=0 and lowest_prio=3; then irr=8'h18 → IR4 wins.
- isr=8'h0A, non-specific EOI → isr=8'h08; specific EOI level 3 with eoi_rotate=1 → isr=0, lowest_prio=3.
- irr=0 at first INTA → isr unchanged, irr_clear=0, vec={base,3'b111}.
- First INTA only, then INTA held high for INTA_TIMEOUT cycles → ack_state returns 0 and isr keeps the set bit; also drop rst_n during GAP → all outputs return to reset values next cycle.
